// File: rtl/fll_auto_truncate_pkg.sv
// rtl/fll_auto_truncate_pkg.sv - shared FLL truncator widths and index-range derivations
package fll_auto_truncate_pkg;

    localparam int DEF_INPUT_WIDTH  = 19;
    localparam int DEF_OUTPUT_WIDTH = 15;
    localparam int DEF_INDEX_WIDTH  = 5;
    localparam int DEF_WINDOW_LEN   = 1024;
    localparam int DEF_WINDOW_WIDTH = 10;

    // Lowest usable index keeps the slice inside the sample; highest leaves the sign bit above it.
    function automatic int min_index(input int output_width);
        return output_width - 2;
    endfunction

    function automatic int max_index(input int input_width);
        return input_width - 2;
    endfunction

endpackage

// File: rtl/fll_auto_truncate_if.sv
// rtl/fll_auto_truncate_if.sv - sample/index bus between the FLL datapath and the truncator
interface fll_auto_truncate_if
    import fll_auto_truncate_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
    parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH
);
    logic                    in_valid;
    logic [INPUT_WIDTH-1:0]  in;
    logic                    auto_en;
    logic [INDEX_WIDTH-1:0]  index_in;
    logic                    out_valid;
    logic [OUTPUT_WIDTH-1:0] out;
    logic                    sat;
    logic [INDEX_WIDTH-1:0]  index_out;
    logic                    index_update;

    modport master (
        output in_valid, in, auto_en, index_in,
        input  out_valid, out, sat, index_out, index_update
    );

    modport slave (
        input  in_valid, in, auto_en, index_in,
        output out_valid, out, sat, index_out, index_update
    );
endinterface

// File: rtl/fll_msb_find.sv
// rtl/fll_msb_find.sv - highest-set-bit priority encoder, 0 for an all-zero vector
module fll_msb_find #(
    parameter int N = 18,
    parameter int W = 5
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] pos
);
    always_comb begin
        pos = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) pos = W'(i);
        end
    end
endmodule

// File: rtl/fll_auto_truncate.sv
// rtl/fll_auto_truncate.sv - registered signed truncator with saturation and windowed peak index tracking
module fll_auto_truncate
    import fll_auto_truncate_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
    parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
    parameter int WINDOW_LEN   = DEF_WINDOW_LEN,
    parameter int WINDOW_WIDTH = DEF_WINDOW_WIDTH
) (
    input logic clk,
    input logic reset,
    fll_auto_truncate_if.slave bus
);
    localparam int MIN_INDEX = min_index(OUTPUT_WIDTH);
    localparam int MAX_INDEX = max_index(INPUT_WIDTH);
    localparam int MAG_WIDTH = INPUT_WIDTH - 1;
    localparam logic [INDEX_WIDTH-1:0]  MIN_IDX  = INDEX_WIDTH'(MIN_INDEX);
    localparam logic [INDEX_WIDTH-1:0]  MAX_IDX  = INDEX_WIDTH'(MAX_INDEX);
    localparam logic [WINDOW_WIDTH-1:0] LAST_CNT = WINDOW_WIDTH'(WINDOW_LEN - 1);

    function automatic logic [INDEX_WIDTH-1:0] clamp_idx(input logic [INDEX_WIDTH-1:0] v);
        if (v < MIN_IDX) return MIN_IDX;
        if (v > MAX_IDX) return MAX_IDX;
        return v;
    endfunction

    logic                    auto_d;
    logic [INDEX_WIDTH-1:0]  idx_q, idx_n;
    logic [WINDOW_WIDTH-1:0] count_q, count_n, count_eff;
    logic [MAG_WIDTH-1:0]    peak_q, peak_n, peak_eff, peak_new, mag;
    logic [INDEX_WIDTH-1:0]  p, p_idx, decay_idx, man_idx, use_idx;
    logic                    seed, update_n, sat_n, sign;
    logic [INPUT_WIDTH-1:0]  shifted;
    logic [OUTPUT_WIDTH-1:0] out_n;

    assign sign     = bus.in[INPUT_WIDTH-1];
    assign seed     = bus.auto_en & ~auto_d;
    assign man_idx  = clamp_idx(bus.index_in);
    // A rising auto_en seeds from index_in, so the seeding cycle already uses the manual value.
    assign use_idx  = (!bus.auto_en || seed) ? man_idx : idx_q;
    assign count_eff = seed ? '0 : count_q;
    assign peak_eff  = seed ? '0 : peak_q;
    assign mag       = bus.in[MAG_WIDTH-1:0] ^ {MAG_WIDTH{sign}};
    assign peak_new  = peak_eff | mag;

    fll_msb_find #(
        .N(MAG_WIDTH),
        .W(INDEX_WIDTH)
    ) u_msb_find (
        .vec(peak_new),
        .pos(p)
    );

    assign p_idx     = clamp_idx(p);
    assign decay_idx = (use_idx > MIN_IDX) ? use_idx - INDEX_WIDTH'(1) : MIN_IDX;

    always_comb begin
        sat_n = 1'b0;
        for (int j = MIN_INDEX + 1; j <= MAX_INDEX; j++) begin
            if ((INDEX_WIDTH'(j) > use_idx) && (bus.in[j] != sign)) sat_n = 1'b1;
        end
    end

    assign shifted = bus.in >> (use_idx - MIN_IDX);
    assign out_n   = sat_n ? {sign, {(OUTPUT_WIDTH-1){~sign}}}
                           : {sign, shifted[OUTPUT_WIDTH-2:0]};

    always_comb begin
        idx_n    = idx_q;
        count_n  = count_q;
        peak_n   = peak_q;
        update_n = 1'b0;
        if (!bus.auto_en) begin
            count_n = '0;
            peak_n  = '0;
            if (bus.in_valid) idx_n = man_idx;
        end else begin
            idx_n   = use_idx;
            count_n = count_eff;
            peak_n  = peak_eff;
            if (bus.in_valid) begin
                if (count_eff == LAST_CNT) begin
                    count_n = '0;
                    peak_n  = '0;
                    // Fast attack to the peak, but decay only one step per window.
                    if (p > use_idx)      idx_n = p_idx;
                    else if (p < use_idx) idx_n = decay_idx;
                    update_n = (idx_n != use_idx);
                end else begin
                    count_n = count_eff + WINDOW_WIDTH'(1);
                    peak_n  = peak_new;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            auto_d           <= 1'b0;
            idx_q            <= MIN_IDX;
            count_q          <= '0;
            peak_q           <= '0;
            bus.out_valid    <= 1'b0;
            bus.out          <= '0;
            bus.sat          <= 1'b0;
            bus.index_update <= 1'b0;
        end else begin
            auto_d           <= bus.auto_en;
            idx_q            <= idx_n;
            count_q          <= count_n;
            peak_q           <= peak_n;
            bus.out_valid    <= bus.in_valid;
            bus.index_update <= update_n;
            if (bus.in_valid) begin
                bus.out <= out_n;
                bus.sat <= sat_n;
            end
        end
    end

    assign bus.index_out = idx_q;

endmodule
